// File: rtl/eth_rx_frame_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : eth_rx_frame_filter                                            |
// | Brief   : Store-and-forward MAC RX buffer; forwards only whole, good,    |
// |           in-length frames and counts each drop cause.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module eth_rx_frame_filter #(
    parameter int axis_data_width_p = 64,
    parameter int els_p             = 512,
    parameter int max_frame_beats_p = 190,
    parameter int cnt_width_p       = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [axis_data_width_p-1:0]   s_axis_tdata_i,
    input  logic [axis_data_width_p/8-1:0] s_axis_tkeep_i,
    input  logic                           s_axis_tvalid_i,
    output logic                           s_axis_tready_o,
    input  logic                           s_axis_tlast_i,
    input  logic                           s_axis_tuser_i,
    output logic [axis_data_width_p-1:0]   m_axis_tdata_o,
    output logic [axis_data_width_p/8-1:0] m_axis_tkeep_o,
    output logic                           m_axis_tvalid_o,
    input  logic                           m_axis_tready_i,
    output logic                           m_axis_tlast_o,
    output logic                           m_axis_tuser_o,
    output logic [cnt_width_p-1:0]         frames_ok_o,
    output logic [cnt_width_p-1:0]         drop_bad_o,
    output logic [cnt_width_p-1:0]         drop_ovf_o,
    output logic [cnt_width_p-1:0]         drop_len_o
);

    localparam int DW  = axis_data_width_p;
    localparam int KW  = axis_data_width_p / 8;
    localparam int EW  = DW + KW + 1;
    localparam int AW  = $clog2(els_p);
    localparam int BCW = $clog2(max_frame_beats_p + 1);
    localparam logic [AW:0]    c_depth     = (AW + 1)'(els_p);
    localparam logic [BCW-1:0] c_max_beats = BCW'(max_frame_beats_p);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                 r_state;
    logic [EW-1:0]          r_mem [els_p];
    logic [AW:0]            r_wr_ptr;
    logic [AW:0]            r_commit_ptr;
    logic [AW:0]            r_rd_ptr;
    logic [BCW-1:0]         r_beat_cnt;
    logic                   r_ready;
    logic [cnt_width_p-1:0] r_frames_ok;
    logic [cnt_width_p-1:0] r_drop_bad;
    logic [cnt_width_p-1:0] r_drop_ovf;
    logic [cnt_width_p-1:0] r_drop_len;

    logic          w_accept;
    logic          w_full;
    logic          w_len_hit;
    logic          w_wr_en;
    logic          w_rd_fire;
    logic [AW:0]   w_occ;
    logic [EW-1:0] w_rd_entry;

    function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // r_ready is low in reset, so it doubles as the "out of reset" qualifier
    assign w_accept   = s_axis_tvalid_i & r_ready;
    assign w_occ      = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_occ == c_depth);
    assign w_len_hit  = (r_beat_cnt == c_max_beats);
    assign w_wr_en    = w_accept && (r_state != DROP) && !w_full && !w_len_hit;
    assign w_rd_fire  = m_axis_tvalid_o & m_axis_tready_i;
    assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];

    assign s_axis_tready_o = r_ready;
    assign m_axis_tvalid_o = (r_rd_ptr != r_commit_ptr);
    assign m_axis_tdata_o  = w_rd_entry[DW-1:0];
    assign m_axis_tkeep_o  = w_rd_entry[DW+KW-1:DW];
    assign m_axis_tlast_o  = w_rd_entry[EW-1];
    assign m_axis_tuser_o  = 1'b0;
    assign frames_ok_o     = r_frames_ok;
    assign drop_bad_o      = r_drop_bad;
    assign drop_ovf_o      = r_drop_ovf;
    assign drop_len_o      = r_drop_len;

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tlast_i, s_axis_tkeep_i, s_axis_tdata_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_beat_cnt   <= '0;
            r_ready      <= 1'b0;
            r_frames_ok  <= '0;
            r_drop_bad   <= '0;
            r_drop_ovf   <= '0;
            r_drop_len   <= '0;
        end else begin
            r_ready <= 1'b1;
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_accept) begin
                case (r_state)
                    IDLE, RECV: begin
                        if (w_full || w_len_hit) begin
                            // Overflow outranks length; the frame is abandoned whole
                            r_wr_ptr   <= r_commit_ptr;
                            r_beat_cnt <= '0;
                            r_state    <= s_axis_tlast_i ? IDLE : DROP;
                            if (w_full) begin
                                r_drop_ovf <= sat_inc(r_drop_ovf);
                            end else begin
                                r_drop_len <= sat_inc(r_drop_len);
                            end
                        end else if (s_axis_tlast_i) begin
                            r_beat_cnt <= '0;
                            r_state    <= IDLE;
                            if (s_axis_tuser_i) begin
                                r_wr_ptr   <= r_commit_ptr;
                                r_drop_bad <= sat_inc(r_drop_bad);
                            end else begin
                                r_wr_ptr     <= r_wr_ptr + 1'b1;
                                r_commit_ptr <= r_wr_ptr + 1'b1;
                                r_frames_ok  <= sat_inc(r_frames_ok);
                            end
                        end else begin
                            r_wr_ptr   <= r_wr_ptr + 1'b1;
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                            r_state    <= RECV;
                        end
                    end
                    DROP: begin
                        if (s_axis_tlast_i) begin
                            r_beat_cnt <= '0;
                            r_state    <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_frame_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_eth_rx_frame_filter                                         |
// | Brief   : Directed bench for eth_rx_frame_filter in three configurations |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_eth_rx_frame_filter;

    logic        clk;
    logic        rst;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic        s_valid;
    logic        s_last;
    logic        s_user;
    logic        m_ready;

    logic        s_ready [3];
    logic [63:0] m_data  [3];
    logic [7:0]  m_keep  [3];
    logic        m_valid [3];
    logic        m_last  [3];
    logic        m_user  [3];
    logic [15:0] c_ok    [3];
    logic [15:0] c_bad   [3];
    logic [15:0] c_ovf   [3];
    logic [15:0] c_len   [3];

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: default sizing, 1: small buffer for overflow, 2: short max length
    eth_rx_frame_filter u_dut0 (
        .clk_i(clk), .reset_i(rst),
        .s_axis_tdata_i(s_data), .s_axis_tkeep_i(s_keep), .s_axis_tvalid_i(s_valid),
        .s_axis_tready_o(s_ready[0]), .s_axis_tlast_i(s_last), .s_axis_tuser_i(s_user),
        .m_axis_tdata_o(m_data[0]), .m_axis_tkeep_o(m_keep[0]), .m_axis_tvalid_o(m_valid[0]),
        .m_axis_tready_i(m_ready), .m_axis_tlast_o(m_last[0]), .m_axis_tuser_o(m_user[0]),
        .frames_ok_o(c_ok[0]), .drop_bad_o(c_bad[0]), .drop_ovf_o(c_ovf[0]), .drop_len_o(c_len[0])
    );

    eth_rx_frame_filter #(.els_p(8), .max_frame_beats_p(8)) u_dut1 (
        .clk_i(clk), .reset_i(rst),
        .s_axis_tdata_i(s_data), .s_axis_tkeep_i(s_keep), .s_axis_tvalid_i(s_valid),
        .s_axis_tready_o(s_ready[1]), .s_axis_tlast_i(s_last), .s_axis_tuser_i(s_user),
        .m_axis_tdata_o(m_data[1]), .m_axis_tkeep_o(m_keep[1]), .m_axis_tvalid_o(m_valid[1]),
        .m_axis_tready_i(m_ready), .m_axis_tlast_o(m_last[1]), .m_axis_tuser_o(m_user[1]),
        .frames_ok_o(c_ok[1]), .drop_bad_o(c_bad[1]), .drop_ovf_o(c_ovf[1]), .drop_len_o(c_len[1])
    );

    eth_rx_frame_filter #(.els_p(16), .max_frame_beats_p(4)) u_dut2 (
        .clk_i(clk), .reset_i(rst),
        .s_axis_tdata_i(s_data), .s_axis_tkeep_i(s_keep), .s_axis_tvalid_i(s_valid),
        .s_axis_tready_o(s_ready[2]), .s_axis_tlast_i(s_last), .s_axis_tuser_i(s_user),
        .m_axis_tdata_o(m_data[2]), .m_axis_tkeep_o(m_keep[2]), .m_axis_tvalid_o(m_valid[2]),
        .m_axis_tready_i(m_ready), .m_axis_tlast_o(m_last[2]), .m_axis_tuser_o(m_user[2]),
        .frames_ok_o(c_ok[2]), .drop_bad_o(c_bad[2]), .drop_ovf_o(c_ovf[2]), .drop_len_o(c_len[2])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at a falling edge
    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        s_valid = 1'b1; s_data = d; s_keep = k; s_last = l; s_user = u;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0;
    endtask

    task automatic do_reset(input int sel);
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready[sel]), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", 64'(s_ready[sel]), 64'd1);
    endtask

    task automatic pop(input int sel, input logic [63:0] d, input logic [7:0] k, input logic l);
        int t = 0;
        m_ready = 1'b1;
        while (!m_valid[sel] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("pop_valid", 64'(m_valid[sel]), 64'd1);
        chk("pop_data", m_data[sel], d);
        chk("pop_keep", 64'(m_keep[sel]), 64'(k));
        chk("pop_last", 64'(m_last[sel]), 64'(l));
        @(negedge clk);
    endtask

    logic [63:0] got [$];

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
        s_user = 1'b0; m_ready = 1'b0;
        @(negedge clk);

        // Test 1: 3-beat good frame, reset state, visibility timing
        do_reset(0);
        chk("t1_rst_ok", 64'(c_ok[0]), 64'd0);
        chk("t1_rst_bad", 64'(c_bad[0]), 64'd0);
        chk("t1_rst_valid", 64'(m_valid[0]), 64'd0);
        chk("t1_tuser", 64'(m_user[0]), 64'd0);
        m_ready = 1'b1;
        beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0, 1'b0);
        beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0, 1'b0);
        chk("t1_valid_before_last", 64'(m_valid[0]), 64'd0);
        beat(64'h0000_0000_3333_3333, 8'h0F, 1'b1, 1'b0);
        chk("t1_valid_after_last", 64'(m_valid[0]), 64'd1);
        pop(0, 64'h1111_1111_1111_1111, 8'hFF, 1'b0);
        pop(0, 64'h2222_2222_2222_2222, 8'hFF, 1'b0);
        pop(0, 64'h0000_0000_3333_3333, 8'h0F, 1'b1);
        chk("t1_empty", 64'(m_valid[0]), 64'd0);
        chk("t1_ok", 64'(c_ok[0]), 64'd1);

        // Test 2: bad 4-beat frame then good 2-beat frame
        do_reset(0);
        beat(64'hBAD0, 8'hFF, 1'b0, 1'b0);
        beat(64'hBAD1, 8'hFF, 1'b0, 1'b0);
        beat(64'hBAD2, 8'hFF, 1'b0, 1'b0);
        beat(64'hBAD3, 8'hFF, 1'b1, 1'b1);
        chk("t2_no_valid_bad", 64'(m_valid[0]), 64'd0);
        beat(64'h600D0, 8'hFF, 1'b0, 1'b0);
        beat(64'h600D1, 8'h03, 1'b1, 1'b0);
        pop(0, 64'h600D0, 8'hFF, 1'b0);
        pop(0, 64'h600D1, 8'h03, 1'b1);
        chk("t2_empty", 64'(m_valid[0]), 64'd0);
        chk("t2_bad", 64'(c_bad[0]), 64'd1);
        chk("t2_ok", 64'(c_ok[0]), 64'd1);

        // Test 3: 8-entry buffer, 6-beat frame then 5-beat frame overflows on beat 3
        do_reset(1);
        for (int i = 0; i < 6; i++) beat(64'hA0 + 64'(i), 8'hFF, i == 5, 1'b0);
        for (int i = 0; i < 5; i++) beat(64'hB0 + 64'(i), 8'hFF, i == 4, 1'b0);
        chk("t3_ovf", 64'(c_ovf[1]), 64'd1);
        chk("t3_ok", 64'(c_ok[1]), 64'd1);
        for (int i = 0; i < 6; i++) pop(1, 64'hA0 + 64'(i), 8'hFF, i == 5);
        repeat (3) @(negedge clk);
        chk("t3_empty", 64'(m_valid[1]), 64'd0);

        // Test 4: max 4 beats; 6-beat frame dropped, 4-beat frame kept
        do_reset(2);
        for (int i = 0; i < 6; i++) beat(64'hC0 + 64'(i), 8'hFF, i == 5, 1'b0);
        chk("t4_len", 64'(c_len[2]), 64'd1);
        for (int i = 0; i < 4; i++) beat(64'hD0 + 64'(i), 8'hFF, i == 3, 1'b0);
        chk("t4_ok", 64'(c_ok[2]), 64'd1);
        chk("t4_ovf", 64'(c_ovf[2]), 64'd0);
        for (int i = 0; i < 4; i++) pop(2, 64'hD0 + 64'(i), 8'hFF, i == 3);
        repeat (3) @(negedge clk);
        chk("t4_empty", 64'(m_valid[2]), 64'd0);

        // Test 5: single-beat frames every cycle while tready toggles
        do_reset(0);
        got.delete();
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = 64'hE000 + 64'(i); s_keep = 8'hFF;
            s_last = 1'b1; s_user = 1'b0;
            m_ready = (i % 2 == 0);
            if (m_valid[0] && m_ready) got.push_back(m_data[0]);
            @(negedge clk);
        end
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (m_valid[0]) got.push_back(m_data[0]);
            @(negedge clk);
        end
        chk("t5_count", 64'(got.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t5_order", (i < got.size()) ? got[i] : 64'hX, 64'hE000 + 64'(i));
        end
        chk("t5_ok", 64'(c_ok[0]), 64'd8);

        // Test 6: reset mid-frame with two committed frames buffered
        do_reset(0);
        beat(64'hF0, 8'hFF, 1'b0, 1'b0);
        beat(64'hF1, 8'hFF, 1'b1, 1'b0);
        beat(64'hF2, 8'hFF, 1'b1, 1'b0);
        beat(64'hF3, 8'hFF, 1'b0, 1'b0);
        chk("t6_ok_before", 64'(c_ok[0]), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_valid_after_rst", 64'(m_valid[0]), 64'd0);
        chk("t6_ok_cleared", 64'(c_ok[0]), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        beat(64'h5A5A, 8'h01, 1'b1, 1'b0);
        pop(0, 64'h5A5A, 8'h01, 1'b1);
        chk("t6_ok_after", 64'(c_ok[0]), 64'd1);
        chk("t6_empty", 64'(m_valid[0]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
